sequential_divider_8_bit: RTL and testbench

//   Unsigned sequential restoring divider: Dividend / Divisor -> Quotient, Remainder.

---
 rtl/sequential_divider_8_bit.sv | 134 +++++++++++++
 tb/tb_sequential_divider_8_bit.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sequential_divider_8_bit.sv
// Unsigned restoring divider: one shift/trial-subtract per clock, result held until next Run.
// Latency: WIDTH cycles from the start edge to Done; divide-by-zero completes on the start edge.
// Backpressure: Run is only sampled in IDLE; Done is held while Run stays high, so no retrigger.
module sequential_divider_8_bit #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             Busy,
  output logic             Done,
  output logic             Div_By_Zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] d_reg, d_nxt;
  logic [WIDTH-1:0] q_reg, q_nxt;
  logic [WIDTH-1:0] r_reg, r_nxt;
  logic [WIDTH-1:0] quo_reg, quo_nxt;
  logic [WIDTH-1:0] rem_reg, rem_nxt;
  logic [CW-1:0]    count, count_nxt;
  logic             dbz_reg, dbz_nxt;

  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] q_iter;
  logic [WIDTH-1:0] r_iter;

  // Trial subtract is one bit wider so its MSB is the borrow: set means "restore".
  always_comb begin
    trial = {r_reg, q_reg[WIDTH-1]} - {1'b0, d_reg};
    if (!trial[WIDTH]) begin
      r_iter = trial[WIDTH-1:0];
      q_iter = {q_reg[WIDTH-2:0], 1'b1};
    end else begin
      r_iter = {r_reg[WIDTH-2:0], q_reg[WIDTH-1]};
      q_iter = {q_reg[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    state_nxt = state;
    d_nxt     = d_reg;
    q_nxt     = q_reg;
    r_nxt     = r_reg;
    quo_nxt   = quo_reg;
    rem_nxt   = rem_reg;
    count_nxt = count;
    dbz_nxt   = dbz_reg;

    unique case (state)
      IDLE: begin
        if (Run) begin
          d_nxt     = Divisor;
          q_nxt     = Dividend;
          r_nxt     = '0;
          count_nxt = '0;
          if (Divisor == '0) begin
            // No iteration needed; publish the saturated result immediately.
            quo_nxt   = {WIDTH{1'b1}};
            rem_nxt   = Dividend;
            dbz_nxt   = 1'b1;
            state_nxt = DONE;
          end else begin
            state_nxt = CALC;
          end
        end
      end

      CALC: begin
        q_nxt     = q_iter;
        r_nxt     = r_iter;
        count_nxt = count + 1'b1;
        if (count == LAST) begin
          quo_nxt   = q_iter;
          rem_nxt   = r_iter;
          state_nxt = DONE;
        end
      end

      DONE: begin
        if (!Run) begin
          dbz_nxt   = 1'b0;
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state   <= IDLE;
      d_reg   <= '0;
      q_reg   <= '0;
      r_reg   <= '0;
      quo_reg <= '0;
      rem_reg <= '0;
      count   <= '0;
      dbz_reg <= 1'b0;
    end else begin
      state   <= state_nxt;
      d_reg   <= d_nxt;
      q_reg   <= q_nxt;
      r_reg   <= r_nxt;
      quo_reg <= quo_nxt;
      rem_reg <= rem_nxt;
      count   <= count_nxt;
      dbz_reg <= dbz_nxt;
    end
  end

  assign Quotient    = quo_reg;
  assign Remainder   = rem_reg;
  assign Div_By_Zero = dbz_reg;
  assign Busy        = (state == CALC);
  assign Done        = (state == DONE);

endmodule

// File: tb/tb_sequential_divider_8_bit.sv
// Randomized and directed checks of the sequential divider against an arithmetic reference model.
module tb_sequential_divider_8_bit;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Run;
  logic [7:0] Dividend;
  logic [7:0] Divisor;
  logic [7:0] Quotient;
  logic [7:0] Remainder;
  logic       Busy;
  logic       Done;
  logic       Div_By_Zero;

  int tests  = 0;
  int failed = 0;

  sequential_divider_8_bit #(.WIDTH(8)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Run         (Run),
    .Dividend    (Dividend),
    .Divisor     (Divisor),
    .Quotient    (Quotient),
    .Remainder   (Remainder),
    .Busy        (Busy),
    .Done        (Done),
    .Div_By_Zero (Div_By_Zero)
  );

  always #5 Clk = ~Clk;

  // Reference: plain integer division, saturated quotient on zero divisor.
  function automatic void ref_div(input int a, input int b,
                                  output int q, output int r, output int dbz);
    if (b == 0) begin
      q = 255; r = a; dbz = 1;
    end else begin
      q = a / b; r = a % b; dbz = 0;
    end
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Pulses Run for one edge from IDLE, then waits (bounded) for Done.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        output int lat, output int busy_n,
                        output logic [7:0] q_mid, output logic [7:0] r_mid);
    Dividend = a;
    Divisor  = b;
    Run      = 1'b1;
    tick();
    Run    = 1'b0;
    q_mid  = Quotient;
    r_mid  = Remainder;
    lat    = 0;
    busy_n = 0;
    while (Done !== 1'b1 && lat < 40) begin
      if (Busy === 1'b1) busy_n++;
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    Reset = 1'b0; Run = 1'b0; Dividend = 8'd0; Divisor = 8'd0;
    tick(); tick();
    tests++;
    if ({Quotient, Remainder, Busy, Done, Div_By_Zero} !== 19'd0) begin
      failed++;
      $display("FAIL reset_state: got Q=%0d R=%0d Busy=%b Done=%b DBZ=%b, want all 0",
               Quotient, Remainder, Busy, Done, Div_By_Zero);
    end
    Reset = 1'b1;
    tick();
  endtask

  task automatic test_directed();
    int a_tab[8] = '{200, 255, 5, 255, 0, 50, 1, 128};
    int b_tab[8] = '{7, 1, 9, 255, 3, 6, 255, 2};
    int lat, busy_n, eq, er, ed;
    logic [7:0] qm, rm;
    for (int i = 0; i < 8; i++) begin
      ref_div(a_tab[i], b_tab[i], eq, er, ed);
      run_op(8'(a_tab[i]), 8'(b_tab[i]), lat, busy_n, qm, rm);
      tests++;
      if (lat != 8 || busy_n != 8) begin
        failed++;
        $display("FAIL directed_latency %0d/%0d: got lat=%0d busy=%0d, want 8/8",
                 a_tab[i], b_tab[i], lat, busy_n);
      end
      tests++;
      if (Quotient !== 8'(eq) || Remainder !== 8'(er) || Div_By_Zero !== 1'b0) begin
        failed++;
        $display("FAIL directed_result %0d/%0d: got Q=%0d R=%0d DBZ=%b, want Q=%0d R=%0d DBZ=0",
                 a_tab[i], b_tab[i], Quotient, Remainder, Div_By_Zero, eq, er);
      end
      tick();
    end
  endtask

  task automatic test_div_by_zero();
    int lat, busy_n;
    logic [7:0] qm, rm;
    run_op(8'd77, 8'd0, lat, busy_n, qm, rm);
    tests++;
    if (lat != 0 || busy_n != 0) begin
      failed++;
      $display("FAIL dbz_latency: got lat=%0d busy=%0d, want 0/0", lat, busy_n);
    end
    tests++;
    if (Quotient !== 8'hFF || Remainder !== 8'd77 || Div_By_Zero !== 1'b1) begin
      failed++;
      $display("FAIL dbz_result: got Q=%0d R=%0d DBZ=%b, want Q=255 R=77 DBZ=1",
               Quotient, Remainder, Div_By_Zero);
    end
    tick();
    tests++;
    if (Done !== 1'b0 || Div_By_Zero !== 1'b0 || Quotient !== 8'hFF || Remainder !== 8'd77) begin
      failed++;
      $display("FAIL dbz_release: got Done=%b DBZ=%b Q=%0d R=%0d, want 0 0 255 77",
               Done, Div_By_Zero, Quotient, Remainder);
    end
  endtask

  task automatic test_run_held();
    int busy_total = 0;
    int done_first = -1;
    Dividend = 8'd100;
    Divisor  = 8'd3;
    Run      = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (c == 1) begin
        Dividend = 8'd9;
        Divisor  = 8'd200;
      end
      if (Busy === 1'b1) busy_total++;
      if (Done === 1'b1 && done_first < 0) done_first = c;
    end
    tests++;
    if (busy_total != 8 || done_first != 8 || Done !== 1'b1) begin
      failed++;
      $display("FAIL run_held_timing: got busy=%0d first_done=%0d Done=%b, want 8 8 1",
               busy_total, done_first, Done);
    end
    tests++;
    if (Quotient !== 8'd33 || Remainder !== 8'd1) begin
      failed++;
      $display("FAIL run_held_result: got Q=%0d R=%0d, want Q=33 R=1", Quotient, Remainder);
    end
    Run = 1'b0;
    tick();
    tests++;
    if (Done !== 1'b0 || Quotient !== 8'd33 || Remainder !== 8'd1) begin
      failed++;
      $display("FAIL run_held_release: got Done=%b Q=%0d R=%0d, want 0 33 1",
               Done, Quotient, Remainder);
    end
  endtask

  task automatic test_reset_mid_calc();
    int lat, busy_n;
    logic [7:0] qm, rm;
    Dividend = 8'd123;
    Divisor  = 8'd5;
    Run      = 1'b1;
    tick();
    Run = 1'b0;
    tick(); tick(); tick();
    tests++;
    if (Busy !== 1'b1) begin
      failed++;
      $display("FAIL reset_mid_busy: got Busy=%b, want 1", Busy);
    end
    Reset = 1'b0;
    tick();
    tests++;
    if ({Quotient, Remainder, Busy, Done, Div_By_Zero} !== 19'd0) begin
      failed++;
      $display("FAIL reset_mid_state: got Q=%0d R=%0d Busy=%b Done=%b DBZ=%b, want all 0",
               Quotient, Remainder, Busy, Done, Div_By_Zero);
    end
    Reset = 1'b1;
    tick();
    run_op(8'd50, 8'd6, lat, busy_n, qm, rm);
    tests++;
    if (Quotient !== 8'd8 || Remainder !== 8'd2 || lat != 8) begin
      failed++;
      $display("FAIL reset_mid_rerun: got Q=%0d R=%0d lat=%0d, want Q=8 R=2 lat=8",
               Quotient, Remainder, lat);
    end
    tick();
  endtask

  task automatic test_random();
    int lat, busy_n, eq, er, ed, a, b;
    logic [7:0] qm, rm, prev_q, prev_r;
    for (int i = 0; i < 1500; i++) begin
      a = (i < 64) ? ((i % 8) * 37 % 256) : int'($urandom_range(0, 255));
      b = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(0, 255));
      if (i < 64) b = (i / 8) * 36;
      prev_q = Quotient;
      prev_r = Remainder;
      ref_div(a, b, eq, er, ed);
      run_op(8'(a), 8'(b), lat, busy_n, qm, rm);
      if (b != 0) begin
        tests++;
        if (qm !== prev_q || rm !== prev_r) begin
          failed++;
          $display("FAIL rand_hold %0d/%0d: mid-CALC Q=%0d R=%0d, want held Q=%0d R=%0d",
                   a, b, qm, rm, prev_q, prev_r);
        end
        tests++;
        if (int'(Quotient) * b + int'(Remainder) != a || int'(Remainder) >= b) begin
          failed++;
          $display("FAIL rand_invariant %0d/%0d: got Q=%0d R=%0d", a, b, Quotient, Remainder);
        end
      end
      tests++;
      if (lat != (ed ? 0 : 8) || busy_n != (ed ? 0 : 8)) begin
        failed++;
        $display("FAIL rand_latency %0d/%0d: got lat=%0d busy=%0d, want %0d",
                 a, b, lat, busy_n, ed ? 0 : 8);
      end
      tests++;
      if (Quotient !== 8'(eq) || Remainder !== 8'(er) || Div_By_Zero !== ed[0]) begin
        failed++;
        $display("FAIL rand_result %0d/%0d: got Q=%0d R=%0d DBZ=%b, want Q=%0d R=%0d DBZ=%0d",
                 a, b, Quotient, Remainder, Div_By_Zero, eq, er, ed);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_div_by_zero();
    test_run_held();
    test_reset_mid_calc();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
